// File: rtl/pc_gen_btb.sv
// Fetch-stage PC generator with a direct-mapped BTB of 2-bit saturating
// counters. Next PC priority: trap, redirect, stall, predicted target, +4.
// The EX stage trains the BTB through the upd_* port, independently of PC
// selection. A lookup sees the table contents from before any same-cycle update.
module pc_gen_btb #(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_PC  = 'h3000,
   parameter int              BTB_DEPTH = 16
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            stall_f,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            trap_valid,
   input  logic [XLEN-1:0] trap_pc,
   input  logic            upd_valid,
   input  logic [XLEN-1:0] upd_pc,
   input  logic [XLEN-1:0] upd_target,
   input  logic            upd_taken,
   output logic [XLEN-1:0] pc_f,
   output logic            pred_taken_f,
   output logic [XLEN-1:0] pred_target_f,
   output logic            redirected_f
);

   localparam int IDX   = $clog2(BTB_DEPTH);
   localparam int TAG_W = XLEN - IDX - 2;
   localparam int TGT_W = XLEN - 2;

   // BTB storage: valid and counters are control state, tag/target are data
   logic             btb_valid [BTB_DEPTH];
   logic [1:0]       btb_ctr   [BTB_DEPTH];
   logic [TAG_W-1:0] btb_tag   [BTB_DEPTH];
   logic [TGT_W-1:0] btb_tgt   [BTB_DEPTH];

   logic [IDX-1:0]   f_idx;
   logic [TAG_W-1:0] f_tag;
   logic             f_hit;
   logic [IDX-1:0]   u_idx;
   logic [TAG_W-1:0] u_tag;
   logic             u_hit;
   logic [XLEN-1:0]  pc_next;
   logic             red_next;

   // Instruction-aligned addresses make the two low bits of these inputs don't-care
   logic unused_lsbs;
   assign unused_lsbs = ^{trap_pc[1:0], redirect_pc[1:0], upd_pc[1:0], upd_target[1:0]};

   function automatic logic [1:0] sat_inc(input logic [1:0] c);
      return (c == 2'b11) ? 2'b11 : c + 2'b01;
   endfunction

   function automatic logic [1:0] sat_dec(input logic [1:0] c);
      return (c == 2'b00) ? 2'b00 : c - 2'b01;
   endfunction

   assign f_idx = pc_f[IDX+1:2];
   assign f_tag = pc_f[XLEN-1:IDX+2];
   assign u_idx = upd_pc[IDX+1:2];
   assign u_tag = upd_pc[XLEN-1:IDX+2];

   // Lookup on the current fetch PC and hit detection for the training port
   always_comb begin
      f_hit         = btb_valid[f_idx] && (btb_tag[f_idx] == f_tag);
      u_hit         = btb_valid[u_idx] && (btb_tag[u_idx] == u_tag);
      pred_taken_f  = f_hit && btb_ctr[f_idx][1];
      pred_target_f = pred_taken_f ? {btb_tgt[f_idx], 2'b00} : '0;
   end

   // Next-PC selection by priority; loaded targets are word aligned
   always_comb begin
      pc_next  = pc_f + XLEN'(4);
      red_next = 1'b0;
      if (trap_valid) begin
         pc_next  = {trap_pc[XLEN-1:2], 2'b00};
         red_next = 1'b1;
      end else if (redirect_valid) begin
         pc_next  = {redirect_pc[XLEN-1:2], 2'b00};
         red_next = 1'b1;
      end else if (stall_f) begin
         pc_next  = pc_f;
      end else if (pred_taken_f) begin
         pc_next  = pred_target_f;
      end
   end

   // Fetch PC register and redirect flag
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pc_f         <= RESET_PC;
         redirected_f <= 1'b0;
      end else begin
         pc_f         <= pc_next;
         redirected_f <= red_next;
      end
   end

   // BTB control training: valid bits and saturating direction counters
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < BTB_DEPTH; i++) begin
            btb_valid[i] <= 1'b0;
            btb_ctr[i]   <= 2'b01;
         end
      end else if (upd_valid) begin
         if (u_hit) begin
            btb_ctr[u_idx] <= upd_taken ? sat_inc(btb_ctr[u_idx]) : sat_dec(btb_ctr[u_idx]);
         end else if (upd_taken) begin
            btb_valid[u_idx] <= 1'b1;
            btb_ctr[u_idx]   <= 2'b10;
         end
      end
   end

   // BTB data training: any taken update writes tag and target (tag unchanged on a hit)
   always_ff @(posedge clk) begin
      if (upd_valid && upd_taken) begin
         btb_tag[u_idx] <= u_tag;
         btb_tgt[u_idx] <= upd_target[XLEN-1:2];
      end
   end

endmodule

// File: tb/tb_pc_gen_btb.sv
// Directed bench for pc_gen_btb: a behavioural reference of the PC selection
// rules and the BTB is compared against the DUT every cycle, with literal
// expectations pinning key points of each scenario.
module tb_pc_gen_btb;

   logic        clk = 1'b0;
   logic        rstn;
   logic        stall_f, redirect_valid, trap_valid, upd_valid, upd_taken;
   logic [31:0] redirect_pc, trap_pc, upd_pc, upd_target;
   logic [31:0] pc_f, pred_target_f;
   logic        pred_taken_f, redirected_f;

   int checks = 0;
   int errors = 0;

   pc_gen_btb #(.XLEN(32), .RESET_PC(32'h3000), .BTB_DEPTH(16)) dut (
      .clk(clk), .rstn(rstn), .stall_f(stall_f),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .trap_valid(trap_valid), .trap_pc(trap_pc),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
      .pc_f(pc_f), .pred_taken_f(pred_taken_f), .pred_target_f(pred_target_f),
      .redirected_f(redirected_f)
   );

   always #5 clk = ~clk;

   // Reference model: 16-entry table indexed by (pc/4)%16, tagged by pc/64
   logic [31:0] m_pc;
   logic        m_red;
   bit          m_v   [16];
   logic [31:0] m_tag [16];
   logic [31:0] m_tgt [16];
   int          m_c   [16];

   function automatic bit m_pred(input logic [31:0] pc);
      int i = int'((pc >> 2) % 16);
      return m_v[i] && (m_tag[i] == (pc >> 6)) && (m_c[i] >= 2);
   endfunction

   function automatic logic [31:0] m_ptgt(input logic [31:0] pc);
      return m_pred(pc) ? m_tgt[int'((pc >> 2) % 16)] : 32'h0;
   endfunction

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_pc  = 32'h3000;
         m_red = 1'b0;
         for (int i = 0; i < 16; i++) begin
            m_v[i] = 1'b0;
            m_c[i] = 1;
         end
      end else begin
         logic [31:0] np;
         bit          nr;
         int          ui;
         bit          uh;
         nr = 1'b0;
         if (trap_valid) begin
            np = trap_pc & ~32'h3; nr = 1'b1;
         end else if (redirect_valid) begin
            np = redirect_pc & ~32'h3; nr = 1'b1;
         end else if (stall_f) begin
            np = m_pc;
         end else if (m_pred(m_pc)) begin
            np = m_ptgt(m_pc);
         end else begin
            np = m_pc + 32'd4;
         end
         if (upd_valid) begin
            ui = int'((upd_pc >> 2) % 16);
            uh = m_v[ui] && (m_tag[ui] == (upd_pc >> 6));
            if (uh && upd_taken) begin
               m_c[ui] = (m_c[ui] < 3) ? m_c[ui] + 1 : 3;
               m_tgt[ui] = upd_target & ~32'h3;
            end else if (uh) begin
               m_c[ui] = (m_c[ui] > 0) ? m_c[ui] - 1 : 0;
            end else if (upd_taken) begin
               m_v[ui] = 1'b1; m_tag[ui] = upd_pc >> 6;
               m_tgt[ui] = upd_target & ~32'h3; m_c[ui] = 2;
            end
         end
         m_pc  = np;
         m_red = nr;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // One cycle: let the edge happen, then compare every output with the model
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      chk("model_pc",   pc_f,                  m_pc);
      chk("model_red",  {31'b0, redirected_f}, {31'b0, m_red});
      chk("model_pt",   {31'b0, pred_taken_f}, {31'b0, m_pred(m_pc)});
      chk("model_ptgt", pred_target_f,         m_ptgt(m_pc));
   endtask

   task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
      upd_valid = 1'b1; upd_pc = pc; upd_target = tgt; upd_taken = tk;
   endtask

   initial begin
      bit pattern [9] = '{0, 0, 0, 1, 1, 1, 1, 0, 0};
      rstn = 1'b1; stall_f = 0; redirect_valid = 0; trap_valid = 0; upd_valid = 0;
      upd_taken = 0; redirect_pc = 0; trap_pc = 0; upd_pc = 0; upd_target = 0;
      #1 rstn = 1'b0;
      // T1 reset and sequential fetch
      tick(); tick();
      chk("rst_pc", pc_f, 32'h3000);
      chk("rst_red", {31'b0, redirected_f}, 32'h0);
      chk("rst_pt", {31'b0, pred_taken_f}, 32'h0);
      chk("rst_ptgt", pred_target_f, 32'h0);
      rstn = 1'b1;
      tick(); chk("seq_3004", pc_f, 32'h3004);
      tick(); chk("seq_3008", pc_f, 32'h3008);
      // T2 stall
      stall_f = 1'b1;
      tick(); tick(); tick(); chk("stall_hold", pc_f, 32'h3008);
      stall_f = 1'b0;
      tick(); chk("stall_resume", pc_f, 32'h300C);
      // T3 trap beats redirect beats stall
      trap_valid = 1; trap_pc = 32'h1C00; redirect_valid = 1; redirect_pc = 32'h4000; stall_f = 1;
      tick(); chk("prio_pc", pc_f, 32'h1C00); chk("prio_red", {31'b0, redirected_f}, 32'h1);
      trap_valid = 0; redirect_valid = 0; stall_f = 0;
      tick(); chk("prio_red_drop", {31'b0, redirected_f}, 32'h0); chk("prio_next", pc_f, 32'h1C04);
      // T4 train 0x3010 -> 0x3100 while redirecting back to 0x3000
      upd(32'h3010, 32'h3100, 1'b1); redirect_valid = 1; redirect_pc = 32'h3000;
      tick(); upd_valid = 0; redirect_valid = 0;
      chk("t4_restart", pc_f, 32'h3000);
      repeat (4) tick();
      chk("t4_pc", pc_f, 32'h3010);
      chk("t4_pt", {31'b0, pred_taken_f}, 32'h1);
      chk("t4_ptgt", pred_target_f, 32'h3100);
      tick(); chk("t4_jump", pc_f, 32'h3100);
      // T5 counter saturation, with an unaligned redirect onto 0x3010 and stall held
      redirect_valid = 1; redirect_pc = 32'h3013;
      tick(); redirect_valid = 0; stall_f = 1;
      chk("t5_align", pc_f, 32'h3010);
      for (int k = 0; k < 9; k++) begin
         upd(32'h3010, 32'h3100, pattern[k]);
         tick();
         if (k == 2) chk("t5_floor", {31'b0, pred_taken_f}, 32'h0);
         if (k == 7) chk("t5_ceiling", {31'b0, pred_taken_f}, 32'h1);
      end
      chk("t5_end", {31'b0, pred_taken_f}, 32'h0);
      upd(32'h3010, 32'h3100, 1'b1); tick();
      chk("t5_retrain", {31'b0, pred_taken_f}, 32'h1);
      upd(32'h3050, 32'h5000, 1'b0); tick();
      chk("miss_nt_nochange", {31'b0, pred_taken_f}, 32'h1);
      // T6 alias replacement and PC wrap
      upd(32'h3050, 32'h5000, 1'b1); tick(); upd_valid = 0;
      chk("alias_miss", {31'b0, pred_taken_f}, 32'h0);
      redirect_valid = 1; redirect_pc = 32'h3050; tick(); redirect_valid = 0;
      chk("alias_hit_tgt", pred_target_f, 32'h5000);
      stall_f = 0; tick(); chk("alias_jump", pc_f, 32'h5000);
      redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC; tick(); redirect_valid = 0;
      chk("wrap_top", pc_f, 32'hFFFF_FFFC);
      tick(); chk("wrap_zero", pc_f, 32'h0);
      // Training continues during a trap; unaligned trap vector
      trap_valid = 1; trap_pc = 32'h2001; upd(32'h3050, 32'h5000, 1'b0);
      tick(); trap_valid = 0; upd_valid = 0;
      chk("trap_align", pc_f, 32'h2000);
      tick(); tick();
      // Reset mid-operation discards a pending update
      upd(32'h3000, 32'h3200, 1'b1); rstn = 1'b0;
      tick(); upd_valid = 0;
      chk("mid_rst_pc", pc_f, 32'h3000);
      chk("mid_rst_pt", {31'b0, pred_taken_f}, 32'h0);
      rstn = 1'b1;
      tick(); chk("post_rst", pc_f, 32'h3004);
      redirect_valid = 1; redirect_pc = 32'h3050; tick(); redirect_valid = 0;
      chk("post_rst_cleared", {31'b0, pred_taken_f}, 32'h0);
      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
